u13_loader: RTL and testbench

U13_LOADER -- requirements
Module: u13_loader

---
 rtl/u13_loader.sv | 110 +++++++++++
 tb/tb_u13_loader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/u13_loader.sv
// Boot loader for the u13 core: streams an image into RAM while holding the
// core in reset, then hands the RAM bus back and releases the core.
module u13_loader #(
    parameter logic [15:0] BASE_ADDR   = 16'h0100,
    parameter int unsigned MAX_BYTES   = 16,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        bus_own,
    output logic        cpu_rst,
    output logic        done,
    output logic [8:0]  count,
    output logic        overflow
);

    localparam int unsigned CW = 9;
    localparam int unsigned HW = 8;
    localparam int unsigned AW = 16;

    typedef enum logic [1:0] {LOAD, FLUSH, HOLD, RUN} state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] count_q;
    logic [HW-1:0] hold_q;
    logic          we_q;
    logic          ovf_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    wdata_q;
    logic          accept_c;
    logic          close_c;

    assign accept_c = (state == LOAD) && in_valid;
    assign close_c  = accept_c &&
                      (in_last || ((count_q + CW'(1)) == CW'(MAX_BYTES)));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (close_c) state_nx = FLUSH;
            FLUSH:   state_nx = HOLD;
            HOLD:    if (hold_q == HW'(1)) state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = LOAD;
        endcase
    end

    // Moore outputs decoded from the state register
    always_comb begin
        in_ready = 1'b0;
        bus_own  = 1'b1;
        cpu_rst  = 1'b1;
        done     = 1'b0;
        case (state)
            LOAD:    in_ready = 1'b1;
            RUN: begin
                bus_own = 1'b0;
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

    // Write path, byte counter, hold timer and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            hold_q  <= '0;
            we_q    <= 1'b0;
            ovf_q   <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
        end else begin
            we_q <= accept_c;
            if (accept_c) begin
                addr_q  <= BASE_ADDR + AW'(count_q);
                wdata_q <= in_data;
                count_q <= count_q + CW'(1);
            end
            if (state == FLUSH)     hold_q <= HW'(HOLD_CYCLES);
            else if (state == HOLD) hold_q <= hold_q - HW'(1);
            if (in_valid && (state != LOAD)) ovf_q <= 1'b1;
        end
    end

    // The RAM samples we on the same edge that applies rst, so gating here
    // keeps a reset from committing the write still in flight.
    assign mem_we    = we_q && !rst;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_u13_loader.sv
// Scoreboard bench for u13_loader: expected RAM writes are queued as bytes
// are issued and popped by a monitor whenever a DUT pulses mem_we.
module tb_u13_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_valid2;

    logic        in_ready, mem_we, bus_own, cpu_rst, done, overflow;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [8:0]  count;

    logic        in_ready2, mem_we2, bus_own2, cpu_rst2, done2, overflow2;
    logic [15:0] mem_addr2;
    logic [7:0]  mem_wdata2;
    logic [8:0]  count2;

    int n_vec = 0;
    int n_err = 0;

    logic [23:0] q1[$];
    logic [23:0] q2[$];

    always #5 clk = ~clk;

    u13_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .bus_own(bus_own),
        .cpu_rst(cpu_rst), .done(done), .count(count), .overflow(overflow)
    );

    u13_loader #(.BASE_ADDR(16'hFFFF)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid2),
        .in_last(in_last), .in_ready(in_ready2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_we(mem_we2), .bus_own(bus_own2),
        .cpu_rst(cpu_rst2), .done(done2), .count(count2), .overflow(overflow2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send2(input logic [7:0] d, input logic l);
        in_data   = d;
        in_last   = l;
        in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: every mem_we pulse must match the head of its queue
    always @(negedge clk) begin
        logic [23:0] e;
        if (mem_we) begin
            if (q1.size() == 0) chk("dut_unexpected_write", {8'h0, mem_addr, mem_wdata}, 32'hDEAD);
            else begin
                e = q1.pop_front();
                chk("dut_wr_addr", 32'(mem_addr), 32'(e[23:8]));
                chk("dut_wr_data", 32'(mem_wdata), 32'(e[7:0]));
            end
        end
        if (mem_we2) begin
            if (q2.size() == 0) chk("dut2_unexpected_write", {8'h0, mem_addr2, mem_wdata2}, 32'hDEAD);
            else begin
                e = q2.pop_front();
                chk("dut2_wr_addr", 32'(mem_addr2), 32'(e[23:8]));
                chk("dut2_wr_data", 32'(mem_wdata2), 32'(e[7:0]));
            end
        end
    end

    initial begin
        rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; in_valid2 = 1'b0;
        step(2);
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_bus_own",  32'(bus_own),  32'd1);
        chk("rst_cpu_rst",  32'(cpu_rst),  32'd1);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_count",    32'(count),    32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_mem_we",   32'(mem_we),   32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0100);
        chk("rst_wdata",    32'(mem_wdata), 32'h00);
        chk("rst_addr2",    32'(mem_addr2), 32'hFFFF);

        // Address wrap on the second instance
        q2.push_back({16'hFFFF, 8'h5A});
        q2.push_back({16'h0000, 8'h5B});
        send2(8'h5A, 1'b0);
        send2(8'h5B, 1'b1);
        chk("wrap_count2", 32'(count2), 32'd2);
        step(6);
        chk("wrap_done2", 32'(done2), 32'd1);

        // Three-byte image, back-to-back
        q1.push_back({16'h0100, 8'hA9});
        q1.push_back({16'h0101, 8'h05});
        q1.push_back({16'h0102, 8'h00});
        send(8'hA9, 1'b0);
        send(8'h05, 1'b0);
        send(8'h00, 1'b1);
        chk("img3_count",    32'(count),    32'd3);
        chk("img3_in_ready", 32'(in_ready), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            chk($sformatf("img3_cpu_rst_hold%0d", k), 32'(cpu_rst), 32'd1);
        end
        step(1);
        chk("img3_cpu_rst_release", 32'(cpu_rst), 32'd0);
        chk("img3_done",            32'(done),    32'd1);
        chk("img3_bus_own",         32'(bus_own), 32'd0);
        chk("img3_overflow",        32'(overflow), 32'd0);

        // Byte offered in RUN
        send(8'h77, 1'b0);
        step(1);
        chk("run_overflow", 32'(overflow), 32'd1);
        chk("run_cpu_rst",  32'(cpu_rst),  32'd0);
        chk("run_count",    32'(count),    32'd3);

        // Bubbles
        do_reset();
        chk("bub_overflow_cleared", 32'(overflow), 32'd0);
        q1.push_back({16'h0100, 8'h11});
        q1.push_back({16'h0101, 8'h22});
        send(8'h11, 1'b0);
        in_data = 8'hEE; in_last = 1'b1;
        step(1);
        chk("bub_count_a", 32'(count), 32'd1);
        step(1);
        chk("bub_count_b", 32'(count), 32'd1);
        send(8'h22, 1'b1);
        chk("bub_count_end", 32'(count), 32'd2);
        step(6);
        chk("bub_done", 32'(done), 32'd1);

        // 20 bytes without last, capped at 16
        do_reset();
        for (int i = 0; i < 16; i++) q1.push_back({16'h0100 + 16'(i), 8'h40 + 8'(i)});
        for (int i = 0; i < 20; i++) begin
            in_data  = 8'h40 + 8'(i);
            in_valid = 1'b1;
            step(1);
            if (i == 15) begin
                chk("cap_in_ready", 32'(in_ready), 32'd0);
                chk("cap_count16",  32'(count),    32'd16);
            end
        end
        in_valid = 1'b0;
        step(6);
        chk("cap_overflow", 32'(overflow), 32'd1);
        chk("cap_count",    32'(count),    32'd16);
        chk("cap_done",     32'(done),     32'd1);

        // Byte offered during reset is dropped
        rst = 1'b1; in_data = 8'hFF; in_valid = 1'b1;
        step(1);
        rst = 1'b0; in_valid = 1'b0;
        chk("rstprio_count",    32'(count),    32'd0);
        chk("rstprio_overflow", 32'(overflow), 32'd0);

        // Reset right after the second handshake cancels its write
        q1.push_back({16'h0100, 8'hB1});
        send(8'hB1, 1'b0);
        send(8'hB2, 1'b0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid_count_rst", 32'(count), 32'd0);
        q1.push_back({16'h0100, 8'hB3});
        send(8'hB3, 1'b1);
        chk("mid_count_restart", 32'(count), 32'd1);
        step(8);

        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
